// File: rtl/lab3_seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner: latches one 16-bit word per frame and
// multiplexes it as hex digits with leading-zero blanking, decimal points and blank time.
module lab3_seven_seg_scan #(
  parameter int REFRESH_DIV      = 100000,
  parameter int BLANK_CYCLES     = 1000,
  parameter int BLANK_LEAD_ZEROS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST_COUNT = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

  logic [PW-1:0] r_prescaler;
  logic [1:0]    r_digitIdx;
  logic [15:0]   r_dataReg;
  logic [3:0]    r_dpReg;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frameStart;

  logic          w_tick;
  logic          w_frameEnd;
  logic [3:0]    w_blank;
  logic [3:0]    w_nibble;
  logic [6:0]    w_font;
  logic          w_visible;

  assign w_tick     = (r_prescaler == LAST_COUNT);
  assign w_frameEnd = w_tick && (r_digitIdx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescaler <= '0;
      r_digitIdx  <= 2'd0;
    end else begin
      r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;
      if (w_tick)
        r_digitIdx <= r_digitIdx + 2'd1;
    end
  end

  // The word is only sampled at the frame wrap so a frame never mixes two words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dataReg    <= 16'h0000;
      r_dpReg      <= 4'h0;
      r_frameStart <= 1'b0;
    end else begin
      r_frameStart <= w_frameEnd;
      if (w_frameEnd) begin
        r_dataReg <= data_in;
        r_dpReg   <= dp_in;
      end
    end
  end

  // A lit decimal point stops the blanking chain at that digit and everything to its right.
  always_comb begin
    w_blank = 4'b0000;
    if (BLANK_LEAD_ZEROS != 0) begin
      w_blank[3] = (r_dataReg[15:12] == 4'h0) && !r_dpReg[3];
      w_blank[2] = w_blank[3] && (r_dataReg[11:8] == 4'h0) && !r_dpReg[2];
      w_blank[1] = w_blank[2] && (r_dataReg[7:4] == 4'h0) && !r_dpReg[1];
    end
  end

  assign w_nibble  = r_dataReg[{r_digitIdx, 2'b00} +: 4];
  assign w_visible = enable && (r_prescaler >= BLANK_END) && !w_blank[r_digitIdx];

  always_comb begin
    w_font = 7'h7F;
    case (w_nibble)
      4'h0: w_font = 7'h40;
      4'h1: w_font = 7'h79;
      4'h2: w_font = 7'h24;
      4'h3: w_font = 7'h30;
      4'h4: w_font = 7'h19;
      4'h5: w_font = 7'h12;
      4'h6: w_font = 7'h02;
      4'h7: w_font = 7'h78;
      4'h8: w_font = 7'h00;
      4'h9: w_font = 7'h10;
      4'hA: w_font = 7'h08;
      4'hB: w_font = 7'h03;
      4'hC: w_font = 7'h46;
      4'hD: w_font = 7'h21;
      4'hE: w_font = 7'h06;
      4'hF: w_font = 7'h0E;
      default: w_font = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_visible ? ~(4'b0001 << r_digitIdx) : 4'b1111;
      r_seg <= w_font;
      r_dp  <= ~(r_dpReg[r_digitIdx] && w_visible);
    end
  end

  assign an          = r_an;
  assign seg         = r_seg;
  assign dp          = r_dp;
  assign frame_start = r_frameStart;

endmodule
